// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder slice reused LSB-first over WIDTH cycles.
// Optional signed-overflow output ovf is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Returns {carry, sum} of a single full-adder slice.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] s_sr_r;
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             ovf_r;

  logic [1:0]       fa_s;
  logic [WIDTH-1:0] s_next_s;

  // Full-adder slice on the current LSBs and the sum register as it will look after this bit.
  always_comb begin
    fa_s     = full_add(a_sr_r[0], b_sr_r[0], c_r);
    s_next_s = {fa_s[0], s_sr_r[WIDTH-1:1]};
  end

  // Sequencer, operand/sum shift registers, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      s_sr_r  <= '0;
      c_r     <= 1'b0;
      cnt_r   <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sr_r  <= A;
            b_sr_r  <= B;
            s_sr_r  <= '0;
            c_r     <= Cin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ADD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ADD: begin
          a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
          s_sr_r <= s_next_s;
          c_r    <= fa_s[1];
          // Counter parks at the last index so it can never wrap.
          if (cnt_r == CNT_LAST) begin
            s_r     <= s_next_s;
            cout_r  <= fa_s[1];
            ovf_r   <= c_r ^ fa_s[1];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign S    = s_r;
  assign Cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_r;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_r;
`endif

endmodule
